// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing the single register-file write port
// between the ALU/MEM path (0) and the multi-cycle MUL (1), DIV (2) and FPU (3)
// units. The winning result is captured in an output register toward WB, so at
// most one result reaches WB per cycle. A drain and a new grant in the same
// cycle replace the held result without a bubble.
module wb_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        valid_in,
    output logic [N_REQ-1:0]        ready_out,
    input  logic [N_REQ-1:0]        rd_wena_in,
    input  logic [N_REQ*ADDR_W-1:0] rd_addr_in,
    input  logic [N_REQ*DATA_W-1:0] rd_data_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    rd_wena_out,
    output logic [ADDR_W-1:0]       rd_addr_out,
    output logic [DATA_W-1:0]       rd_data_out,
    output logic [ID_W-1:0]         grant_id_out
);

    // Index of the most recent winner; the search starts just after it.
    logic [ID_W-1:0]   ptr;

    logic              load;
    logic              grant_hit;
    logic              grant;
    logic [ID_W-1:0]   grant_idx;

    logic [ADDR_W-1:0] addr_slice [N_REQ];
    logic [DATA_W-1:0] data_slice [N_REQ];

    // Modular successor that stays correct when N_REQ is not a power of two.
    // base < N_REQ and off <= N_REQ, so a single subtraction is enough.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int              off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    // Unpack the flat per-requester buses into indexable slices.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_slice[i] = rd_addr_in[i*ADDR_W +: ADDR_W];
            data_slice[i] = rd_data_in[i*DATA_W +: DATA_W];
        end
    end

    // Output register may take a new result when empty or draining; flush blocks it.
    always_comb begin
        load = (!valid_out || ready_in) && !flush;
    end

    // Round-robin search from ptr+1 around to ptr; the first valid requester wins.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_hit && valid_in[wrap_add(ptr, k)]) begin
                grant_hit = 1'b1;
                grant_idx = wrap_add(ptr, k);
            end
        end
    end

    // Accept is one-hot toward the winner only when the output register can load.
    always_comb begin
        grant     = grant_hit && load;
        ready_out = '0;
        if (grant) begin
            ready_out[grant_idx] = 1'b1;
        end
    end

    // Output register and priority pointer; flush outranks grant, grant outranks drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out    <= 1'b0;
            rd_wena_out  <= 1'b0;
            rd_addr_out  <= '0;
            rd_data_out  <= '0;
            grant_id_out <= '0;
            ptr          <= ID_W'(N_REQ - 1);
        end else if (flush) begin
            valid_out   <= 1'b0;
            rd_wena_out <= 1'b0;
        end else if (grant) begin
            valid_out    <= 1'b1;
            rd_wena_out  <= rd_wena_in[grant_idx];
            rd_addr_out  <= addr_slice[grant_idx];
            rd_data_out  <= data_slice[grant_idx];
            grant_id_out <= grant_idx;
            ptr          <= grant_idx;
        end else if (valid_out && ready_in) begin
            valid_out   <= 1'b0;
            rd_wena_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run, all checked
// against a behavioural model of the round-robin write-back port.
module tb_wb_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int OW = 2 + AW + DW + IW;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            flush = 1'b0;
    logic            ready_in = 1'b0;
    logic [N-1:0]    valid_in = '0;
    logic [N-1:0]    rd_wena_in = '1;
    logic [AW-1:0]   req_addr [N];
    logic [DW-1:0]   req_data [N];
    logic [N*AW-1:0] rd_addr_in;
    logic [N*DW-1:0] rd_data_in;

    logic [N-1:0]    ready_out;
    logic            valid_out;
    logic            rd_wena_out;
    logic [AW-1:0]   rd_addr_out;
    logic [DW-1:0]   rd_data_out;
    logic [IW-1:0]   grant_id_out;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int            m_ptr;
    logic          m_valid;
    logic          m_wena;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_gid;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign rd_addr_in[i*AW +: AW] = req_addr[i];
        assign rd_data_in[i*DW +: DW] = req_data[i];
    end

    wire [OW-1:0] dut_out = {valid_out, rd_wena_out, rd_addr_out, rd_data_out, grant_id_out};

    wb_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .rd_wena_in   (rd_wena_in),
        .rd_addr_in   (rd_addr_in),
        .rd_data_in   (rd_data_in),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .rd_wena_out  (rd_wena_out),
        .rd_addr_out  (rd_addr_out),
        .rd_data_out  (rd_data_out),
        .grant_id_out (grant_id_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_ptr   = N - 1;
        m_valid = 1'b0;
        m_wena  = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_gid   = 0;
    endfunction

    // first valid requester searching ptr+1, ptr+2, ... modulo N; -1 if none
    function automatic int model_pick();
        for (int k = 1; k <= N; k++) begin
            int c = (m_ptr + k) % N;
            if (valid_in[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit model_load();
        return (!m_valid || ready_in) && !flush;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r = '0;
        int g = model_pick();
        if (g >= 0 && model_load()) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [OW-1:0] model_out();
        return {m_valid, m_wena, m_addr, m_data, IW'(m_gid)};
    endfunction

    // advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        int g;
        bit ld;
        g  = model_pick();
        ld = model_load();
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_wena  = 1'b0;
        end else if (g >= 0 && ld) begin
            m_valid = 1'b1;
            m_wena  = rd_wena_in[g];
            m_addr  = req_addr[g];
            m_data  = req_data[g];
            m_gid   = g;
            m_ptr   = g;
        end else if (m_valid && ready_in) begin
            m_valid = 1'b0;
            m_wena  = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        valid_in = 4'b1111;
        tick();
        tick();
        n_tests++;
        if (dut_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", dut_out);
        end
        valid_in = '0;
        reset    = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        req_addr[0] = 6'd5;
        req_data[0] = 32'hDEADBEEF;
        rd_wena_in  = '1;
        valid_in    = 4'b0001;
        ready_in    = 1'b1;
        #1;
        n_tests++;
        if (ready_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 0001", ready_out);
        end
        tick();
        valid_in = '0;
        n_tests++;
        if (dut_out !== {1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 2'd0}) begin
            n_fail++;
            $display("FAIL single_out: got %h expected %h", dut_out,
                     {1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 2'd0});
        end
        tick();
        n_tests++;
        if (valid_out !== 1'b0 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL single_drain: got %h expected %h", dut_out, model_out());
        end
    endtask

    task automatic test_round_robin();
        valid_in = 4'b1111;
        ready_in = 1'b1;
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < N; i++) begin
                req_addr[i] = AW'($urandom);
                req_data[i] = $urandom;
            end
            #1;
            n_tests++;
            if (ready_out !== model_ready()) begin
                n_fail++;
                $display("FAIL rr_ready cyc %0d: got %b expected %b", c, ready_out, model_ready());
            end
            tick();
            n_tests++;
            if (valid_out !== 1'b1 || dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL rr_out cyc %0d: got %h expected %h", c, dut_out, model_out());
            end
        end
        valid_in = '0;
        tick();
    endtask

    task automatic test_stall();
        logic [N-1:0] hs;
        valid_in = 4'b1010;
        ready_in = 1'b1;
        #1;
        hs = model_ready();
        tick();
        valid_in = valid_in & ~hs;
        valid_in = 4'b1010;
        ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (ready_out !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_ready cyc %0d: got %b expected 0000", c, ready_out);
            end
            tick();
            n_tests++;
            if (dut_out !== model_out() || valid_out !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: got %h expected %h", c, dut_out, model_out());
            end
        end
        ready_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (ready_out !== model_ready()) begin
                n_fail++;
                $display("FAIL stall_rel_ready cyc %0d: got %b expected %b", c, ready_out, model_ready());
            end
            hs = model_ready();
            tick();
            valid_in = valid_in & ~hs;
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL stall_rel_out cyc %0d: got %h expected %h", c, dut_out, model_out());
            end
        end
        valid_in = '0;
        tick();
    endtask

    task automatic test_flush();
        valid_in = 4'b0001;
        ready_in = 1'b1;
        tick();
        valid_in = 4'b0010;
        flush    = 1'b1;
        #1;
        n_tests++;
        if (ready_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_ready: got %b expected 0000", ready_out);
        end
        tick();
        flush = 1'b0;
        n_tests++;
        if (valid_out !== 1'b0 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL flush_clear: got %h expected %h", dut_out, model_out());
        end
        #1;
        n_tests++;
        if (ready_out !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_next_ready: got %b expected 0010", ready_out);
        end
        tick();
        valid_in = '0;
        n_tests++;
        if (grant_id_out !== 2'd1 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL flush_next_grant: got %h expected %h", dut_out, model_out());
        end
        tick();
    endtask

    task automatic test_reset_mid();
        valid_in = 4'b1111;
        ready_in = 1'b1;
        tick();
        valid_in = '0;
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (dut_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 0", dut_out);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        valid_in = 4'b1111;
        #1;
        n_tests++;
        if (ready_out !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid_ready: got %b expected 0001", ready_out);
        end
        tick();
        valid_in = '0;
        n_tests++;
        if (grant_id_out !== 2'd0 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL reset_mid_grant: got %h expected %h", dut_out, model_out());
        end
        tick();
    endtask

    task automatic test_no_wena();
        rd_wena_in  = 4'b1011;
        req_addr[2] = 6'd33;
        req_data[2] = 32'h0BAD_F00D;
        valid_in    = 4'b0100;
        ready_in    = 1'b1;
        tick();
        valid_in = '0;
        n_tests++;
        if (valid_out !== 1'b1 || rd_wena_out !== 1'b0 || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL no_wena_out: got %h expected %h", dut_out, model_out());
        end
        tick();
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL no_wena_drain: got valid %b expected 0", valid_out);
        end
        rd_wena_in = '1;
    endtask

    task automatic test_random();
        logic [N-1:0] hs;
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid_in[i] && $urandom_range(0, 2) == 0) begin
                    valid_in[i]   = 1'b1;
                    rd_wena_in[i] = ($urandom_range(0, 3) != 0);
                    req_addr[i]   = AW'($urandom);
                    req_data[i]   = $urandom;
                end
            end
            ready_in = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            n_tests++;
            if (ready_out !== model_ready()) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_ready cyc %0d: got %b expected %b", c, ready_out, model_ready());
            end
            hs = model_ready();
            tick();
            n_tests++;
            if (dut_out !== model_out()) begin
                n_fail++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_out cyc %0d: got %h expected %h", c, dut_out, model_out());
            end
            if (flush) valid_in = '0;
            else       valid_in = valid_in & ~hs;
            flush = 1'b0;
        end
        valid_in = '0;
        ready_in = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            req_addr[i] = '0;
            req_data[i] = '0;
        end
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_flush();
        test_reset_mid();
        test_no_wena();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
